ctrl_pipe: RTL and testbench

- Consumer end of the main-decoder control interface.
- Accepts the decoded control word and register fields from the ID stage.
- Carries them through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards (stall), resolves BEQ/BNE in EX (flush), and counts inserted bubbles for debug.

---
 rtl/ctrl_pkg.sv | 37 +++
 rtl/hazard_unit.sv | 42 ++++
 rtl/ctrl_pipe.sv | 120 ++++++++++++
 tb/tb_ctrl_pipe.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared control-word layout, opcode constants and destination-select helper.
// No logic state; constants and a pure function only.
// Imported by ctrl_pipe, hazard_unit and the bench.
package ctrl_pkg;

  localparam int CTRL_CW = 12;
  localparam int CTRL_RW = 5;

  // Control-word bit positions
  localparam int B_BRANCHNOT = 11;
  localparam int B_JUMP      = 10;
  localparam int B_REGWRITE  = 9;
  localparam int B_REGDST    = 8;
  localparam int B_ALUSRC    = 7;
  localparam int B_BRANCH    = 6;
  localparam int B_MEMWRITE  = 5;
  localparam int B_MEMTOREG  = 4;
  localparam int B_ALUOP_HI  = 3;
  localparam int B_ALUOP_LO  = 0;

  localparam logic [CTRL_CW-1:0] BUBBLE_CTRL = '0;

  // Decoder words for the common opcodes
  localparam logic [CTRL_CW-1:0] CTRL_R   = 12'h302;
  localparam logic [CTRL_CW-1:0] CTRL_LW  = 12'h290;
  localparam logic [CTRL_CW-1:0] CTRL_SW  = 12'h0A0;
  localparam logic [CTRL_CW-1:0] CTRL_BEQ = 12'h041;
  localparam logic [CTRL_CW-1:0] CTRL_BNE = 12'h841;

  // R-type writes rd, everything else writes rt
  function automatic logic [CTRL_RW-1:0] sel_wreg(input logic regdst,
                                                  input logic [CTRL_RW-1:0] rd,
                                                  input logic [CTRL_RW-1:0] rt);
    return regdst ? rd : rt;
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// Load-use stall and BEQ/BNE branch resolution for the instruction pair in ID/EX.
// Latency: purely combinational.
// Backpressure: stall asks upstream to hold PC and IF/ID; a taken branch overrides it.
module hazard_unit #(
  parameter int RW = 5
) (
  input  logic          i_ex_branch,
  input  logic          i_ex_branchnot,
  input  logic          i_ex_memtoreg,
  input  logic          i_ex_regwrite,
  input  logic [RW-1:0] i_ex_wreg,
  input  logic          i_ex_zero,
  input  logic          i_id_valid,
  input  logic          i_id_alusrc,
  input  logic          i_id_memwrite,
  input  logic          i_id_branch,
  input  logic [RW-1:0] i_id_rs,
  input  logic [RW-1:0] i_id_rt,
  output logic          o_stall,
  output logic          o_branch_taken
);

  logic w_branch_taken;
  logic w_rt_used;
  logic w_load_in_ex;
  logic w_dep;

  // BNE inverts the sense of the zero flag
  assign w_branch_taken = i_ex_branch & (i_ex_zero ^ i_ex_branchnot);

  // rt is a real source unless it is only the immediate-form destination
  assign w_rt_used = ~i_id_alusrc | i_id_memwrite | i_id_branch;

  // $0 is never a hazard: writes to it are discarded
  assign w_load_in_ex = i_ex_memtoreg & i_ex_regwrite & (i_ex_wreg != '0);
  assign w_dep        = (i_ex_wreg == i_id_rs) | (w_rt_used & (i_ex_wreg == i_id_rt));

  // A wrong-path ID instruction is flushed anyway, so never stall it
  assign o_stall        = i_id_valid & ~w_branch_taken & w_load_in_ex & w_dep;
  assign o_branch_taken = w_branch_taken;

endmodule

// File: rtl/ctrl_pipe.sv
// Carries decoded control and destination register through ID/EX, EX/MEM, MEM/WB.
// Latency: ID->EX 1 cycle, ->MEM 2, ->WB 3.
// Backpressure: stall holds upstream only; EX->MEM->WB always advance.
module ctrl_pipe #(
  parameter int CW    = 12,
  parameter int RW    = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [CW-1:0]    id_ctrl,
  input  logic [RW-1:0]    id_rs,
  input  logic [RW-1:0]    id_rt,
  input  logic [RW-1:0]    id_rd,
  input  logic             ex_zero,
  output logic [CW-1:0]    ex_ctrl,
  output logic [RW-1:0]    ex_wreg,
  output logic [CW-1:0]    mem_ctrl,
  output logic [RW-1:0]    mem_wreg,
  output logic             wb_regwrite,
  output logic             wb_memtoreg,
  output logic [RW-1:0]    wb_wreg,
  output logic             stall,
  output logic             branch_taken,
  output logic [CNT_W-1:0] bubble_count
);

  import ctrl_pkg::*;

  logic [CW-1:0]    r_ex_ctrl;
  logic [RW-1:0]    r_ex_wreg;
  logic [CW-1:0]    r_mem_ctrl;
  logic [RW-1:0]    r_mem_wreg;
  logic             r_wb_regwrite;
  logic             r_wb_memtoreg;
  logic [RW-1:0]    r_wb_wreg;
  logic [CNT_W-1:0] r_bubble_count;

  logic [RW-1:0]    w_id_wreg;
  logic             w_stall;
  logic             w_branch_taken;
  logic             w_kill;
  logic             w_bubble;

  assign w_id_wreg = sel_wreg(id_ctrl[B_REGDST], id_rd, id_rt);

  hazard_unit #(.RW(RW)) u_hazard (
    .i_ex_branch    (r_ex_ctrl[B_BRANCH]),
    .i_ex_branchnot (r_ex_ctrl[B_BRANCHNOT]),
    .i_ex_memtoreg  (r_ex_ctrl[B_MEMTOREG]),
    .i_ex_regwrite  (r_ex_ctrl[B_REGWRITE]),
    .i_ex_wreg      (r_ex_wreg),
    .i_ex_zero      (ex_zero),
    .i_id_valid     (id_valid),
    .i_id_alusrc    (id_ctrl[B_ALUSRC]),
    .i_id_memwrite  (id_ctrl[B_MEMWRITE]),
    .i_id_branch    (id_ctrl[B_BRANCH]),
    .i_id_rs        (id_rs),
    .i_id_rt        (id_rt),
    .o_stall        (w_stall),
    .o_branch_taken (w_branch_taken)
  );

  // Only stall/flush bubbles are counted; idle ID slots are not
  assign w_kill   = w_branch_taken | w_stall;
  assign w_bubble = w_kill | ~id_valid;

  // ID/EX capture: flush or stall or idle ID inserts a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_ctrl <= BUBBLE_CTRL;
      r_ex_wreg <= '0;
    end else if (w_bubble) begin
      r_ex_ctrl <= BUBBLE_CTRL;
      r_ex_wreg <= '0;
    end else begin
      r_ex_ctrl <= id_ctrl;
      r_ex_wreg <= w_id_wreg;
    end
  end

  // EX/MEM and MEM/WB advance unconditionally every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_ctrl    <= BUBBLE_CTRL;
      r_mem_wreg    <= '0;
      r_wb_regwrite <= 1'b0;
      r_wb_memtoreg <= 1'b0;
      r_wb_wreg     <= '0;
    end else begin
      r_mem_ctrl    <= r_ex_ctrl;
      r_mem_wreg    <= r_ex_wreg;
      r_wb_regwrite <= r_mem_ctrl[B_REGWRITE];
      r_wb_memtoreg <= r_mem_ctrl[B_MEMTOREG];
      r_wb_wreg     <= r_mem_wreg;
    end
  end

  // Saturating bubble counter for debug visibility
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bubble_count <= '0;
    end else if (w_kill && (r_bubble_count != '1)) begin
      r_bubble_count <= r_bubble_count + CNT_W'(1);
    end
  end

  assign ex_ctrl      = r_ex_ctrl;
  assign ex_wreg      = r_ex_wreg;
  assign mem_ctrl     = r_mem_ctrl;
  assign mem_wreg     = r_mem_wreg;
  assign wb_regwrite  = r_wb_regwrite;
  assign wb_memtoreg  = r_wb_memtoreg;
  assign wb_wreg      = r_wb_wreg;
  assign stall        = w_stall;
  assign branch_taken = w_branch_taken;
  assign bubble_count = r_bubble_count;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: directed scenarios then random traffic against a queue model.
// Two DUTs share inputs; the second has a 2-bit counter to exercise saturation.
module tb_ctrl_pipe;
  import ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [11:0] id_ctrl;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        ex_zero;

  logic [11:0] ex_ctrl, mem_ctrl;
  logic [4:0]  ex_wreg, mem_wreg, wb_wreg;
  logic        wb_regwrite, wb_memtoreg, stall, branch_taken;
  logic [15:0] bubble_count;

  logic [11:0] s_ex_ctrl, s_mem_ctrl;
  logic [4:0]  s_ex_wreg, s_mem_wreg, s_wb_wreg;
  logic        s_wb_regwrite, s_wb_memtoreg, s_stall, s_branch_taken;
  logic [1:0]  s_bubble_count;

  always #5 clk = ~clk;

  ctrl_pipe #(.CW(12), .RW(5), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
    .ex_ctrl(ex_ctrl), .ex_wreg(ex_wreg), .mem_ctrl(mem_ctrl), .mem_wreg(mem_wreg),
    .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_wreg(wb_wreg),
    .stall(stall), .branch_taken(branch_taken), .bubble_count(bubble_count)
  );

  ctrl_pipe #(.CW(12), .RW(5), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
    .ex_ctrl(s_ex_ctrl), .ex_wreg(s_ex_wreg), .mem_ctrl(s_mem_ctrl), .mem_wreg(s_mem_wreg),
    .wb_regwrite(s_wb_regwrite), .wb_memtoreg(s_wb_memtoreg), .wb_wreg(s_wb_wreg),
    .stall(s_stall), .branch_taken(s_branch_taken), .bubble_count(s_bubble_count)
  );

  // Reference model: a 3-deep queue of {ctrl, wreg}; index 0 = EX, 1 = MEM, 2 = WB
  typedef struct packed {
    logic [11:0] c;
    logic [4:0]  w;
  } stage_t;

  stage_t pipe[$];
  int     cnt;
  int     cnt2;
  int     n_assert = 0;
  int     n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    pipe = {};
    repeat (3) pipe.push_back('0);
    cnt  = 0;
    cnt2 = 0;
  endtask

  function automatic logic model_bt();
    return pipe[0].c[6] && (ex_zero != pipe[0].c[11]);
  endfunction

  function automatic logic model_stall();
    logic rt_used;
    logic load;
    rt_used = !id_ctrl[7] || id_ctrl[5] || id_ctrl[6];
    load    = pipe[0].c[4] && pipe[0].c[9] && (pipe[0].w != 0);
    return id_valid && !model_bt() && load &&
           ((pipe[0].w == id_rs) || (rt_used && (pipe[0].w == id_rt)));
  endfunction

  task automatic check_all();
    chk("ex_ctrl",      32'(ex_ctrl),        32'(pipe[0].c));
    chk("ex_wreg",      32'(ex_wreg),        32'(pipe[0].w));
    chk("mem_ctrl",     32'(mem_ctrl),       32'(pipe[1].c));
    chk("mem_wreg",     32'(mem_wreg),       32'(pipe[1].w));
    chk("wb_regwrite",  32'(wb_regwrite),    32'(pipe[2].c[9]));
    chk("wb_memtoreg",  32'(wb_memtoreg),    32'(pipe[2].c[4]));
    chk("wb_wreg",      32'(wb_wreg),        32'(pipe[2].w));
    chk("stall",        32'(stall),          32'(model_stall()));
    chk("branch_taken", 32'(branch_taken),   32'(model_bt()));
    chk("bubble_count", 32'(bubble_count),   32'(cnt));
    chk("sat_count",    32'(s_bubble_count), 32'(cnt2));
  endtask

  // One clock: drive, check mid-cycle, advance model on the edge
  task automatic cycle(input logic v, input logic [11:0] c, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic z,
                       input logic rst, input int exp_stall, input int exp_bt);
    logic   bt, st;
    stage_t n;
    id_valid = v; id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd;
    ex_zero  = z; reset = rst;
    #4;
    check_all();
    if (exp_stall >= 0) chk("stall_directed", 32'(stall), 32'(exp_stall));
    if (exp_bt >= 0)    chk("bt_directed", 32'(branch_taken), 32'(exp_bt));
    bt = model_bt();
    st = model_stall();
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      n = (bt || st || !v) ? '0 : '{c: c, w: (c[8] ? rd : rt)};
      pipe.push_front(n);
      void'(pipe.pop_back());
      if (bt || st) begin
        cnt  = (cnt < 65535) ? cnt + 1 : cnt;
        cnt2 = (cnt2 < 3) ? cnt2 + 1 : cnt2;
      end
    end
    #1;
  endtask

  initial begin
    logic [11:0] rc;
    // Reset held two cycles with a live R-type presented
    reset = 1'b1; id_valid = 1'b1; id_ctrl = CTRL_R;
    id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3; ex_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    check_all();
    chk("rst_ex_ctrl",  32'(ex_ctrl), 32'h0);
    chk("rst_mem_ctrl", 32'(mem_ctrl), 32'h0);
    chk("rst_wb_rw",    32'(wb_regwrite), 32'h0);
    chk("rst_count",    32'(bubble_count), 32'h0);

    // Latency through the three stages
    cycle(1'b1, CTRL_R, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 0, 0);
    chk("lat_ex", 32'(ex_ctrl), 32'h302);
    chk("lat_ex_wreg", 32'(ex_wreg), 32'd3);
    cycle(1'b0, CTRL_R, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 0, 0);
    chk("lat_mem", 32'(mem_ctrl), 32'h302);
    cycle(1'b0, CTRL_R, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 0, 0);
    chk("lat_wb_rw", 32'(wb_regwrite), 32'h1);
    chk("lat_wb_wreg", 32'(wb_wreg), 32'd3);
    chk("idle_no_count", 32'(bubble_count), 32'h0);

    // Load-use on rs: one stall, one bubble, then the held R-type enters
    cycle(1'b1, CTRL_LW, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0, 0, 0);
    cycle(1'b1, CTRL_R,  5'd8, 5'd1, 5'd4, 1'b0, 1'b0, 1, 0);
    chk("lu_bubble", 32'(ex_ctrl), 32'h0);
    chk("lu_count", 32'(bubble_count), 32'd1);
    cycle(1'b1, CTRL_R,  5'd8, 5'd1, 5'd4, 1'b0, 1'b0, 0, 0);
    chk("lu_replay", 32'(ex_ctrl), 32'h302);
    chk("lu_replay_wreg", 32'(ex_wreg), 32'd4);

    // Load into $0 never stalls
    cycle(1'b1, CTRL_LW, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 0, 0);
    cycle(1'b1, CTRL_R,  5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 0, 0);
    chk("zero_reg_count", 32'(bubble_count), 32'd1);

    // BEQ taken flushes; BNE with zero=1 does not
    cycle(1'b1, CTRL_BEQ, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 0, 0);
    cycle(1'b1, CTRL_R,   5'd3, 5'd4, 5'd6, 1'b1, 1'b0, 0, 1);
    chk("beq_flush", 32'(ex_ctrl), 32'h0);
    chk("beq_count", 32'(bubble_count), 32'd2);
    cycle(1'b1, CTRL_BNE, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 0, 0);
    cycle(1'b1, CTRL_R,   5'd3, 5'd4, 5'd6, 1'b1, 1'b0, 0, 0);
    chk("bne_pass", 32'(ex_ctrl), 32'h302);
    chk("bne_count", 32'(bubble_count), 32'd2);

    // Load-use and taken branch together: one bubble, no stall
    cycle(1'b1, 12'h2D1, 5'd0, 5'd9, 5'd0, 1'b0, 1'b0, 0, 0);
    cycle(1'b1, CTRL_R,  5'd9, 5'd1, 5'd2, 1'b1, 1'b0, 0, 1);
    chk("both_flush", 32'(ex_ctrl), 32'h0);
    chk("both_count", 32'(bubble_count), 32'd3);

    // Saturation of the 2-bit counter after five stalls
    cycle(1'b0, CTRL_R, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, -1, -1);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, CTRL_LW, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 0, 0);
      cycle(1'b1, CTRL_SW, 5'd1, 5'd7, 5'd0, 1'b0, 1'b0, 1, 0);
    end
    chk("sat_stick", 32'(s_bubble_count), 32'd3);
    chk("wide_five", 32'(bubble_count), 32'd5);

    // Mid-stream reset discards everything in flight
    cycle(1'b1, CTRL_R, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 0, 0);
    cycle(1'b1, CTRL_LW, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, -1, -1);
    chk("mrst_ex", 32'(ex_ctrl), 32'h0);
    chk("mrst_ex_wreg", 32'(ex_wreg), 32'h0);
    chk("mrst_mem", 32'(mem_ctrl), 32'h0);
    chk("mrst_wb_rw", 32'(wb_regwrite), 32'h0);
    chk("mrst_count", 32'(bubble_count), 32'h0);
    chk("mrst_sat", 32'(s_bubble_count), 32'h0);

    // Random traffic with small register numbers so hazards are frequent
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 5))
        0: rc = CTRL_R;
        1: rc = CTRL_LW;
        2: rc = CTRL_SW;
        3: rc = CTRL_BEQ;
        4: rc = CTRL_BNE;
        default: rc = 12'($urandom);
      endcase
      cycle(($urandom_range(0, 7) != 0), rc,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 99) == 0), -1, -1);
    end
    #4;
    check_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
